weight_line_buffer: RTL and testbench

Ping-pong weight buffer directly downstream of the Avalon weight read master. Captures the stream of bus-width weight lines (enable/line/ready strobes) into one of two banks. It hands a completed bank to the compute datapath, which reads it by line index and then releases it. It also returns a bank-free flag upstream, so the top FSM only issues a new read start when a bank can accept it.

---
 rtl/weight_line_buffer_pkg.sv | 9 +
 rtl/weight_line_buffer_ram.sv | 23 ++
 rtl/weight_line_buffer.sv | 96 +++++++++
 tb/tb_weight_line_buffer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/weight_line_buffer_pkg.sv
// weight_line_buffer_pkg: shared bank-state encoding and buffer geometry
package weight_line_buffer_pkg;
    localparam int WLB_DEPTH = 16;
    localparam int WLB_ADDRW = 4;
    typedef logic [1:0] bank_state_t;
    localparam bank_state_t ST_EMPTY   = 2'd0;
    localparam bank_state_t ST_FILLING = 2'd1;
    localparam bank_state_t ST_FULL    = 2'd2;
endpackage

// File: rtl/weight_line_buffer_ram.sv
// wlb_bank_ram: one bank of line storage, one write port and one registered read port
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr/rdata read port, rdata updates the cycle after re
module wlb_bank_ram #(
    parameter int W     = 512,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/weight_line_buffer.sv
// weight_line_buffer: ping-pong bank buffer between the weight read master and the compute datapath
//   clk, rst                       clock, asynchronous active-high reset
//   wb_enable_i/wb_line_i/wb_ready_i  incoming line stream and load-complete pulse
//   buf_free_o                     a bank is EMPTY and may take a new load
//   bank_valid_o/bank_lines_o      read bank is FULL, and its line count
//   rd_en_i/rd_addr_i              read request, data on rd_data_o/rd_valid_o a cycle later
//   rd_release_i                   consumer is done with the read bank
//   err_overflow_o/err_clr_i       sticky dropped-line flag and its clear
module weight_line_buffer
    import weight_line_buffer_pkg::*;
#(
    parameter int BUSWIDTH = 512,
    parameter int DEPTH    = WLB_DEPTH,
    parameter int ADDRW    = WLB_ADDRW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_enable_i,
    input  logic [BUSWIDTH-1:0] wb_line_i,
    input  logic                wb_ready_i,
    output logic                buf_free_o,
    output logic                bank_valid_o,
    output logic [ADDRW:0]      bank_lines_o,
    input  logic                rd_en_i,
    input  logic [ADDRW-1:0]    rd_addr_i,
    output logic [BUSWIDTH-1:0] rd_data_o,
    output logic                rd_valid_o,
    input  logic                rd_release_i,
    output logic                err_overflow_o,
    input  logic                err_clr_i
);
    bank_state_t [1:0]    state;
    logic [1:0][ADDRW:0]  count;
    logic                 wr_bank, rd_bank, rd_bank_q, in_range_q;
    logic [ADDRW:0]       wr_ptr;
    logic [BUSWIDTH-1:0]  q [2];
    bank_state_t          wr_st;
    logic                 accept, drop, load_done, rd_ok, rel;

    assign wr_st        = state[wr_bank];
    assign accept       = wb_enable_i && wr_st != ST_FULL && wr_ptr != (ADDRW+1)'(DEPTH);
    assign drop         = wb_enable_i && !accept;
    // a ready with nothing written (bank still EMPTY, no accepted line) is ignored
    assign load_done    = wb_ready_i && wr_st != ST_FULL && (wr_st != ST_EMPTY || accept);
    assign bank_valid_o = state[rd_bank] == ST_FULL;
    assign bank_lines_o = bank_valid_o ? count[rd_bank] : '0;
    assign buf_free_o   = state[0] == ST_EMPTY || state[1] == ST_EMPTY;
    assign rd_ok        = rd_en_i && bank_valid_o;
    assign rel          = rd_release_i && bank_valid_o;
    assign rd_data_o    = rd_valid_o && in_range_q ? q[rd_bank_q] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wlb_bank_ram #(.W(BUSWIDTH), .DEPTH(DEPTH), .AW(ADDRW)) u_ram (
            .clk   (clk),
            .we    (accept && wr_bank == 1'(b)),
            .waddr (wr_ptr[ADDRW-1:0]),
            .wdata (wb_line_i),
            .re    (rd_ok && rd_bank == 1'(b)),
            .raddr (rd_addr_i),
            .rdata (q[b])
        );
    end

    // the released bank is FULL while the written bank is not, so both updates never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= '0;
            count          <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_ptr         <= '0;
            err_overflow_o <= 1'b0;
            rd_valid_o     <= 1'b0;
            rd_bank_q      <= 1'b0;
            in_range_q     <= 1'b0;
        end else begin
            if (rel) begin
                state[rd_bank] <= ST_EMPTY;
                rd_bank        <= ~rd_bank;
            end
            if (load_done) begin
                state[wr_bank] <= ST_FULL;
                count[wr_bank] <= wr_ptr + (ADDRW+1)'(accept);
                wr_bank        <= ~wr_bank;
                wr_ptr         <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + (ADDRW+1)'(1);
                if (wr_st == ST_EMPTY) state[wr_bank] <= ST_FILLING;
            end
            err_overflow_o <= err_clr_i ? 1'b0 : err_overflow_o || drop;
            rd_valid_o     <= rd_ok;
            rd_bank_q      <= rd_bank;
            in_range_q     <= rd_ok && {1'b0, rd_addr_i} < count[rd_bank];
        end
    end
endmodule

// File: tb/tb_weight_line_buffer.sv
// tb_weight_line_buffer: directed self-checking bench for weight_line_buffer
module tb_weight_line_buffer;
    logic         clk = 0, rst = 1;
    logic         wb_enable = 0, wb_ready = 0, rd_en = 0, rd_release = 0, err_clr = 0;
    logic [511:0] wb_line = '0;
    logic [3:0]   rd_addr = '0;
    logic         buf_free, bank_valid, rd_valid, err_overflow;
    logic [4:0]   bank_lines;
    logic [511:0] rd_data;
    int pass = 0, total = 0;

    always #5 clk = ~clk;

    weight_line_buffer dut (
        .clk(clk), .rst(rst),
        .wb_enable_i(wb_enable), .wb_line_i(wb_line), .wb_ready_i(wb_ready),
        .buf_free_o(buf_free), .bank_valid_o(bank_valid), .bank_lines_o(bank_lines),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .rd_release_i(rd_release), .err_overflow_o(err_overflow), .err_clr_i(err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
        wb_enable = 0; wb_ready = 0; rd_en = 0; rd_release = 0; err_clr = 0;
    endtask

    task automatic write_line(input logic [511:0] d, input logic last);
        wb_enable = 1; wb_line = d; wb_ready = last;
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        total++; if (buf_free !== 1'b1) $display("FAIL reset_buf_free got %b exp 1", buf_free); else pass++;
        total++; if (bank_valid !== 1'b0) $display("FAIL reset_bank_valid got %b exp 0", bank_valid); else pass++;
        total++; if (bank_lines !== 5'd0) $display("FAIL reset_lines got %0d exp 0", bank_lines); else pass++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else pass++;
        total++; if (rd_data !== '0) $display("FAIL reset_rd_data got %0h exp 0", rd_data); else pass++;
        total++; if (err_overflow !== 1'b0) $display("FAIL reset_err got %b exp 0", err_overflow); else pass++;
        @(negedge clk);
        rst = 0;
        step();
    endtask

    task automatic test_basic();
        write_line(512'hA0, 0);
        write_line(512'hA1, 0);
        write_line(512'hA2, 0);
        write_line(512'hA3, 1);
        total++; if (bank_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", bank_valid); else pass++;
        total++; if (bank_lines !== 5'd4) $display("FAIL basic_lines got %0d exp 4", bank_lines); else pass++;
        total++; if (buf_free !== 1'b1) $display("FAIL basic_free got %b exp 1", buf_free); else pass++;
        rd_en = 1; rd_addr = 4'd2;
        step();
        total++; if (rd_valid !== 1'b1) $display("FAIL basic_rd_valid got %b exp 1", rd_valid); else pass++;
        total++; if (rd_data !== 512'hA2) $display("FAIL basic_rd_data got %0h exp a2", rd_data); else pass++;
        rd_en = 1; rd_addr = 4'd5;
        step();
        total++; if (rd_valid !== 1'b1) $display("FAIL oob_rd_valid got %b exp 1", rd_valid); else pass++;
        total++; if (rd_data !== '0) $display("FAIL oob_rd_data got %0h exp 0", rd_data); else pass++;
        step();
        total++; if (rd_valid !== 1'b0) $display("FAIL idle_rd_valid got %b exp 0", rd_valid); else pass++;
        rd_release = 1;
        step();
        total++; if (bank_valid !== 1'b0) $display("FAIL basic_release got %b exp 0", bank_valid); else pass++;
    endtask

    task automatic test_overflow();
        write_line(512'hB0, 0);
        write_line(512'hB1, 0);
        write_line(512'hB2, 1);
        write_line(512'hC0, 0);
        write_line(512'hC1, 1);
        total++; if (buf_free !== 1'b0) $display("FAIL both_full_free got %b exp 0", buf_free); else pass++;
        total++; if (bank_lines !== 5'd3) $display("FAIL both_full_lines got %0d exp 3", bank_lines); else pass++;
        total++; if (err_overflow !== 1'b0) $display("FAIL pre_drop_err got %b exp 0", err_overflow); else pass++;
        write_line(512'hDD, 0);
        total++; if (err_overflow !== 1'b1) $display("FAIL drop_err got %b exp 1", err_overflow); else pass++;
        rd_release = 1;
        step();
        total++; if (bank_valid !== 1'b1) $display("FAIL swap_valid got %b exp 1", bank_valid); else pass++;
        total++; if (bank_lines !== 5'd2) $display("FAIL swap_lines got %0d exp 2", bank_lines); else pass++;
        total++; if (buf_free !== 1'b1) $display("FAIL swap_free got %b exp 1", buf_free); else pass++;
        rd_en = 1; rd_addr = 4'd1;
        step();
        total++; if (rd_data !== 512'hC1) $display("FAIL swap_rd_data got %0h exp c1", rd_data); else pass++;
        rd_release = 1;
        step();
        total++; if (bank_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", bank_valid); else pass++;
        err_clr = 1;
        step();
        total++; if (err_overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", err_overflow); else pass++;
    endtask

    task automatic test_depth();
        for (int i = 0; i < 17; i++) begin
            write_line(512'h100 + 512'(i), 0);
            if (i == 15) begin
                total++; if (err_overflow !== 1'b0) $display("FAIL depth16_err got %b exp 0", err_overflow); else pass++;
            end
        end
        total++; if (err_overflow !== 1'b1) $display("FAIL depth17_err got %b exp 1", err_overflow); else pass++;
        wb_ready = 1;
        step();
        total++; if (bank_lines !== 5'd16) $display("FAIL depth_lines got %0d exp 16", bank_lines); else pass++;
        rd_en = 1; rd_addr = 4'd15;
        step();
        total++; if (rd_data !== 512'h10F) $display("FAIL depth_rd_data got %0h exp 10f", rd_data); else pass++;
        err_clr = 1; wb_enable = 1; wb_line = 512'h1;
        rd_release = 1;
        step();
        total++; if (err_overflow !== 1'b0) $display("FAIL clr_priority_err got %b exp 0", err_overflow); else pass++;
        wb_ready = 1;
        step();
        total++; if (bank_lines !== 5'd1) $display("FAIL after_clr_lines got %0d exp 1", bank_lines); else pass++;
        rd_release = 1;
        step();
    endtask

    task automatic test_empty_ready();
        wb_ready = 1;
        step();
        total++; if (bank_valid !== 1'b0) $display("FAIL empty_ready_valid got %b exp 0", bank_valid); else pass++;
        total++; if (buf_free !== 1'b1) $display("FAIL empty_ready_free got %b exp 1", buf_free); else pass++;
        rd_en = 1; rd_addr = 4'd0;
        step();
        total++; if (rd_valid !== 1'b0) $display("FAIL no_bank_rd_valid got %b exp 0", rd_valid); else pass++;
        total++; if (rd_data !== '0) $display("FAIL no_bank_rd_data got %0h exp 0", rd_data); else pass++;
    endtask

    task automatic test_read_release();
        write_line(512'h55, 1);
        total++; if (bank_lines !== 5'd1) $display("FAIL one_line_lines got %0d exp 1", bank_lines); else pass++;
        rd_en = 1; rd_addr = 4'd0; rd_release = 1;
        step();
        total++; if (rd_valid !== 1'b1) $display("FAIL rr_rd_valid got %b exp 1", rd_valid); else pass++;
        total++; if (rd_data !== 512'h55) $display("FAIL rr_rd_data got %0h exp 55", rd_data); else pass++;
        total++; if (bank_valid !== 1'b0) $display("FAIL rr_valid got %b exp 0", bank_valid); else pass++;
    endtask

    task automatic test_reset_midload();
        write_line(512'h77, 1);
        write_line(512'h88, 0);
        write_line(512'h99, 0);
        total++; if (bank_valid !== 1'b1) $display("FAIL pre_rst_valid got %b exp 1", bank_valid); else pass++;
        rst = 1;
        #1;
        total++; if (bank_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bank_valid); else pass++;
        total++; if (bank_lines !== 5'd0) $display("FAIL rst_lines got %0d exp 0", bank_lines); else pass++;
        total++; if (buf_free !== 1'b1) $display("FAIL rst_free got %b exp 1", buf_free); else pass++;
        @(negedge clk);
        rst = 0;
        step();
        write_line(512'hBEEF, 1);
        total++; if (bank_lines !== 5'd1) $display("FAIL post_rst_lines got %0d exp 1", bank_lines); else pass++;
        rd_en = 1; rd_addr = 4'd0;
        step();
        total++; if (rd_data !== 512'hBEEF) $display("FAIL post_rst_rd_data got %0h exp beef", rd_data); else pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_depth();
        test_empty_ready();
        test_read_release();
        test_reset_midload();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
